dds_cmd_sched: RTL and testbench
================================

# dds_cmd_sched

Byte-stream command scheduler between the USB FIFO receiver and the signal generator. It parses framed commands from `cmd_buf` bytes into shadow registers for waveform, frequency, amplitude and phase. It commits the shadow set to the active outputs either immediately or on the generator's phase-wrap pulse, so parameter changes never tear a waveform period. It replaces free-running byte decoding with checksum, timeout and error accounting.

## Interface
Parameters:
- `TIMEOUT_CYC`, 100000: maximum idle cycles between bytes inside a frame before the frame is aborted.
- `DEF_WAVE`, 5'd0: reset/default waveform select.
- `DEF_FREQ`, 8'd1: reset/default frequency word.
- `DEF_AMP`, 8'd255: reset/default amplitude.
- `DEF_PHASE`, 8'd0: reset/default phase.

Ports:
- `clk`, in, 1: single clock. One clock; all logic on its rising edge.
- `rst`, in, 1: reset, synchronous and active-high.
- `rx_data`, in, 8: received byte.
- `rx_valid`, in, 1: one-cycle strobe; `rx_data` is valid this cycle.
- `sync_pulse`, in, 1: one-cycle pulse from the generator at phase-accumulator wrap.
- `state`, out, 5: active waveform select.
- `state_freq`, out, 8: active frequency word.
- `state_amp`, out, 8: active amplitude.
- `state_phase`, out, 8: active phase offset.
- `cfg_update`, out, 1: one-cycle pulse in the cycle after the active registers load.
- `commit_pending`, out, 1: a deferred commit is waiting for `sync_pulse`.
- `err_cnt`, out, 8: saturating count of bad frames.

## Operation
- Frame format, 4 bytes: `0xA5`, OPC, VAL, CHK. The frame is valid when CHK == OPC ^ VAL.
- Parser FSM: HUNT -> OPC -> VAL -> CHK -> EXEC -> HUNT. Each transition out of HUNT/OPC/VAL/CHK consumes exactly one `rx_valid`.
- HUNT discards every byte other than `0xA5`. Discards do not increment `err_cnt`.
- OPC/VAL/CHK latch `rx_data` on `rx_valid`.
- Bad checksum at CHK: go to HUNT and increment `err_cnt`. Nothing is written.
- EXEC lasts one cycle, ignores `rx_valid`, and decodes OPC:
  - 0x01: shadow wave <= VAL[4:0].
  - 0x02: shadow freq <= VAL.
  - 0x03: shadow amp <= VAL.
  - 0x04: shadow phase <= VAL.
  - 0x10: set `commit_pending`. This is a deferred commit.
  - 0x11: immediate commit. The active registers load the shadow set in the next cycle, and any pending commit is cleared.
  - 0x20: shadow and active registers <= defaults, `commit_pending` cleared, `cfg_update` pulsed.
  - Any other OPC: `err_cnt` +1. Nothing else changes.
- Deferred commit: on `sync_pulse` with `commit_pending`=1, the active registers load the shadow values registered at that edge, `commit_pending` clears, and `cfg_update` pulses next cycle.
- `sync_pulse` with no pending commit has no effect.
- Timeout: in OPC/VAL/CHK, an idle counter resets on each `rx_valid`. On reaching `TIMEOUT_CYC` the FSM returns to HUNT and `err_cnt` increments.
- `err_cnt` saturates at 255. Only `rst` clears it.

## Timing
- Reset values:
  - `state`=`DEF_WAVE`, `state_freq`=`DEF_FREQ`, `state_amp`=`DEF_AMP`, `state_phase`=`DEF_PHASE`.
  - Shadow registers equal the active registers.
  - `cfg_update`=0, `commit_pending`=0, `err_cnt`=0.
  - FSM=HUNT, idle counter=0.
- `rst` mid-frame aborts the frame with no error count and drops any pending commit.
- Latency, CHK byte strobe to shadow update: 2 cycles (CHK latch, then EXEC write).
- Latency, 0x11 CHK strobe to active update: 3 cycles. `cfg_update` is high in cycle 4.
- Latency, 0x10 CHK strobe to `commit_pending`=1: 2 cycles.
- Simultaneous events:
  - EXEC setting `commit_pending` in the same cycle as `sync_pulse`: pending is set and the commit waits for the next `sync_pulse`.
  - EXEC writing a shadow in the same cycle as a deferred commit: the active registers get the pre-write shadow value. The new value stays in shadow.
  - `rx_valid` arriving during EXEC is dropped. Upstream guarantees at least a 1-cycle byte gap.
- All outputs are registered. There are no combinational paths from inputs to outputs.

## Test plan
- Reset, then frame A5 02 40 42, then 0x11 commit frame A5 11 00 11 -> `state_freq`=0x40 three cycles after the commit CHK strobe, with one `cfg_update` pulse. Other outputs stay at their defaults.
- Frame A5 03 80 83, then A5 10 00 10 -> `commit_pending`=1 and `state_amp` stays 255 until `sync_pulse`. `state_amp`=0x80 after the pulse. `commit_pending`=0.
- Frame A5 01 03 FF (bad CHK) -> `err_cnt`=1 and no shadow change. The next valid frame A5 01 03 02 plus an immediate commit -> `state`=3.
- A5 04 then silence for `TIMEOUT_CYC` cycles -> FSM in HUNT and `err_cnt`+1. A following full frame is accepted normally.
- Deferred commit pending, then a shadow write EXEC coinciding with `sync_pulse` -> the active register gets the old shadow value. A second commit + `sync_pulse` delivers the new value.
- 300 bad frames -> `err_cnt` holds 255. Then A5 20 00 20 -> all outputs at defaults, `cfg_update` pulsed, `err_cnt` still 255.

Source files
------------

// File: rtl/dds_cmd_sched.sv
// rtl/dds_cmd_sched.sv - framed byte command parser with shadow/active DDS parameter commit
module dds_cmd_sched #(
  parameter int unsigned TIMEOUT_CYC = 100000,
  parameter logic [4:0]  DEF_WAVE    = 5'd0,
  parameter logic [7:0]  DEF_FREQ    = 8'd1,
  parameter logic [7:0]  DEF_AMP     = 8'd255,
  parameter logic [7:0]  DEF_PHASE   = 8'd0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] rx_data,
  input  logic       rx_valid,
  input  logic       sync_pulse,
  output logic [4:0] state,
  output logic [7:0] state_freq,
  output logic [7:0] state_amp,
  output logic [7:0] state_phase,
  output logic       cfg_update,
  output logic       commit_pending,
  output logic [7:0] err_cnt
);

  localparam int IW = $clog2(TIMEOUT_CYC + 1);

  typedef enum logic [2:0] {S_HUNT, S_OPC, S_VAL, S_CHK, S_EXEC} st_e;

  st_e         st_q;
  logic [7:0]  opc_q, val_q;
  logic [IW-1:0] idle_q;
  logic [4:0]  sh_wave_q, wave_q;
  logic [7:0]  sh_freq_q, sh_amp_q, sh_phase_q;
  logic [7:0]  freq_q, amp_q, phase_q;
  logic        pending_q, commit_req_q, loaded_q, cfg_update_q;
  logic [7:0]  err_q, err_d;
  logic        frame_wait, timeout, bad_chk, bad_opc, load_now;

  always_comb begin
    frame_wait = (st_q == S_OPC) || (st_q == S_VAL) || (st_q == S_CHK);
    timeout    = frame_wait && !rx_valid && (idle_q == IW'(TIMEOUT_CYC - 1));
    bad_chk    = (st_q == S_CHK) && rx_valid && (rx_data != (opc_q ^ val_q));
    bad_opc    = (st_q == S_EXEC) &&
                 !(opc_q inside {8'h01, 8'h02, 8'h03, 8'h04, 8'h10, 8'h11, 8'h20});
    err_d      = ((timeout || bad_chk || bad_opc) && (err_q != 8'hFF)) ? err_q + 8'd1 : err_q;
    // an immediate commit request and a sync-qualified deferred commit share one load path
    load_now   = commit_req_q || (sync_pulse && pending_q);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      st_q         <= S_HUNT;
      opc_q        <= 8'h00;
      val_q        <= 8'h00;
      idle_q       <= '0;
      sh_wave_q    <= DEF_WAVE;
      sh_freq_q    <= DEF_FREQ;
      sh_amp_q     <= DEF_AMP;
      sh_phase_q   <= DEF_PHASE;
      wave_q       <= DEF_WAVE;
      freq_q       <= DEF_FREQ;
      amp_q        <= DEF_AMP;
      phase_q      <= DEF_PHASE;
      pending_q    <= 1'b0;
      commit_req_q <= 1'b0;
      loaded_q     <= 1'b0;
      cfg_update_q <= 1'b0;
      err_q        <= 8'h00;
    end else begin
      err_q        <= err_d;
      commit_req_q <= 1'b0;
      loaded_q     <= 1'b0;
      cfg_update_q <= loaded_q;

      if (!frame_wait || rx_valid || timeout) idle_q <= '0;
      else                                    idle_q <= idle_q + IW'(1);

      if (load_now) begin
        wave_q    <= sh_wave_q;
        freq_q    <= sh_freq_q;
        amp_q     <= sh_amp_q;
        phase_q   <= sh_phase_q;
        pending_q <= 1'b0;
        loaded_q  <= 1'b1;
      end

      case (st_q)
        S_HUNT: if (rx_valid && rx_data == 8'hA5) st_q <= S_OPC;
        S_OPC: begin
          if (rx_valid) begin
            opc_q <= rx_data;
            st_q  <= S_VAL;
          end else if (timeout) st_q <= S_HUNT;
        end
        S_VAL: begin
          if (rx_valid) begin
            val_q <= rx_data;
            st_q  <= S_CHK;
          end else if (timeout) st_q <= S_HUNT;
        end
        S_CHK: begin
          if (rx_valid)     st_q <= bad_chk ? S_HUNT : S_EXEC;
          else if (timeout) st_q <= S_HUNT;
        end
        S_EXEC: begin
          st_q <= S_HUNT;
          // statements here follow the load above so EXEC wins on pending and defaults
          case (opc_q)
            8'h01: sh_wave_q  <= val_q[4:0];
            8'h02: sh_freq_q  <= val_q;
            8'h03: sh_amp_q   <= val_q;
            8'h04: sh_phase_q <= val_q;
            8'h10: pending_q  <= 1'b1;
            8'h11: begin
              commit_req_q <= 1'b1;
              pending_q    <= 1'b0;
            end
            8'h20: begin
              sh_wave_q  <= DEF_WAVE;
              sh_freq_q  <= DEF_FREQ;
              sh_amp_q   <= DEF_AMP;
              sh_phase_q <= DEF_PHASE;
              wave_q     <= DEF_WAVE;
              freq_q     <= DEF_FREQ;
              amp_q      <= DEF_AMP;
              phase_q    <= DEF_PHASE;
              pending_q  <= 1'b0;
              loaded_q   <= 1'b1;
            end
            default: ;
          endcase
        end
        default: st_q <= S_HUNT;
      endcase
    end
  end

  assign state          = wave_q;
  assign state_freq     = freq_q;
  assign state_amp      = amp_q;
  assign state_phase    = phase_q;
  assign cfg_update     = cfg_update_q;
  assign commit_pending = pending_q;
  assign err_cnt        = err_q;

endmodule

// File: tb/tb_dds_cmd_sched.sv
// tb/tb_dds_cmd_sched.sv - scoreboard bench for dds_cmd_sched
module tb_dds_cmd_sched;
  localparam int TO = 40;

  typedef struct packed {
    logic [4:0] w;
    logic [7:0] f;
    logic [7:0] a;
    logic [7:0] p;
  } cfg_t;

  localparam cfg_t DEF = '{w: 5'd0, f: 8'd1, a: 8'd255, p: 8'd0};

  logic       clk = 1'b0;
  logic       rst, rx_valid, sync_pulse;
  logic [7:0] rx_data;
  logic [4:0] state;
  logic [7:0] state_freq, state_amp, state_phase, err_cnt;
  logic       cfg_update, commit_pending;
  cfg_t       act, sh, old, mon_e;
  cfg_t       exp_q[$];
  int         checks = 0;
  int         errors = 0;

  dds_cmd_sched #(.TIMEOUT_CYC(TO)) dut (
    .clk(clk), .rst(rst), .rx_data(rx_data), .rx_valid(rx_valid),
    .sync_pulse(sync_pulse), .state(state), .state_freq(state_freq),
    .state_amp(state_amp), .state_phase(state_phase), .cfg_update(cfg_update),
    .commit_pending(commit_pending), .err_cnt(err_cnt)
  );

  always #5 clk = ~clk;
  assign act = {state, state_freq, state_amp, state_phase};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // every cfg_update pulse must retire exactly one predicted configuration
  always @(negedge clk) begin
    if (cfg_update === 1'b1) begin
      if (exp_q.size() == 0) chk("cfg_update_unexpected", 32'd1, 32'd0);
      else begin
        mon_e = exp_q.pop_front();
        chk("commit_value", act, mon_e);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    tick();
    rx_data  = b;
    rx_valid = 1'b1;
    tick();
    rx_valid = 1'b0;
  endtask

  task automatic send_frame(input logic [7:0] o, input logic [7:0] v, input logic [7:0] c);
    send_byte(8'hA5);
    send_byte(o);
    send_byte(v);
    send_byte(c);
  endtask

  task automatic wframe(input logic [7:0] o, input logic [7:0] v);
    send_frame(o, v, o ^ v);
    case (o)
      8'h01: sh.w = v[4:0];
      8'h02: sh.f = v;
      8'h03: sh.a = v;
      8'h04: sh.p = v;
      8'h11: exp_q.push_back(sh);
      8'h20: begin
        sh = DEF;
        exp_q.push_back(DEF);
      end
      default: ;
    endcase
  endtask

  task automatic pulse_sync(input bit load, input cfg_t e);
    sync_pulse = 1'b1;
    if (load) exp_q.push_back(e);
    tick();
    sync_pulse = 1'b0;
  endtask

  initial begin
    rst = 1'b1; rx_valid = 1'b0; rx_data = 8'h00; sync_pulse = 1'b0;
    sh = DEF;
    repeat (3) tick();
    rst = 1'b0;
    tick();
    chk("reset_active", act, DEF);
    chk("reset_pending", commit_pending, 0);
    chk("reset_err", err_cnt, 0);
    chk("reset_cfg_update", cfg_update, 0);

    // junk in HUNT, freq write, immediate commit with latency checks
    send_byte(8'h00); send_byte(8'h5A); send_byte(8'hFF);
    wframe(8'h02, 8'h40);
    chk("hunt_discard_err", err_cnt, 0);
    wframe(8'h11, 8'h00);
    tick();
    chk("imm_freq_e1", state_freq, 8'h01);
    tick();
    chk("imm_freq_e2", state_freq, 8'h40);
    chk("imm_upd_e2", cfg_update, 0);
    tick();
    chk("imm_upd_e3", cfg_update, 1);
    chk("imm_others", act, {5'd0, 8'h40, 8'hFF, 8'h00});
    tick();
    chk("imm_upd_e4", cfg_update, 0);

    // deferred commit waits for sync
    wframe(8'h03, 8'h80);
    wframe(8'h10, 8'h00);
    tick();
    chk("defer_pending", commit_pending, 1);
    repeat (5) tick();
    chk("defer_amp_hold", state_amp, 8'hFF);
    pulse_sync(1'b1, sh);
    chk("defer_amp_new", state_amp, 8'h80);
    chk("defer_pending_clr", commit_pending, 0);
    pulse_sync(1'b0, sh);
    repeat (4) tick();
    chk("idle_sync_amp", state_amp, 8'h80);

    // bad checksum, then good wave frame
    send_frame(8'h01, 8'h03, 8'hFF);
    chk("badchk_err", err_cnt, 1);
    wframe(8'h11, 8'h00);
    repeat (4) tick();
    chk("badchk_no_write", state, 5'd0);
    wframe(8'h01, 8'h03);
    wframe(8'h11, 8'h00);
    repeat (4) tick();
    chk("wave_commit", state, 5'd3);
    wframe(8'h33, 8'h5A);
    tick();
    chk("bad_opc_err", err_cnt, 2);

    // inter-byte timeout
    send_byte(8'hA5);
    send_byte(8'h04);
    repeat (TO - 5) tick();
    chk("timeout_early", err_cnt, 2);
    repeat (10) tick();
    chk("timeout_err", err_cnt, 3);
    wframe(8'h04, 8'h33);
    wframe(8'h11, 8'h00);
    repeat (4) tick();
    chk("after_timeout_phase", state_phase, 8'h33);

    // shadow write coinciding with deferred commit
    wframe(8'h02, 8'h55);
    wframe(8'h10, 8'h00);
    repeat (3) tick();
    chk("coinc_pending", commit_pending, 1);
    old = sh;
    wframe(8'h02, 8'h66);
    pulse_sync(1'b1, old);
    chk("coinc_old_freq", state_freq, 8'h55);
    chk("coinc_pending_clr", commit_pending, 0);
    wframe(8'h10, 8'h00);
    pulse_sync(1'b0, sh);
    chk("set_vs_sync_pending", commit_pending, 1);
    chk("set_vs_sync_freq", state_freq, 8'h55);
    repeat (3) tick();
    pulse_sync(1'b1, sh);
    chk("second_commit_freq", state_freq, 8'h66);

    // saturation and defaults opcode
    repeat (300) send_frame(8'h01, 8'h03, 8'h00);
    chk("err_saturate", err_cnt, 8'hFF);
    wframe(8'h77, 8'h00);
    tick();
    chk("err_sat_opc", err_cnt, 8'hFF);
    wframe(8'h02, 8'h99);
    wframe(8'h10, 8'h00);
    wframe(8'h20, 8'h00);
    tick();
    chk("defaults_active", act, DEF);
    chk("defaults_pending", commit_pending, 0);
    tick();
    chk("defaults_upd", cfg_update, 1);
    chk("defaults_err", err_cnt, 8'hFF);

    // reset mid-frame with a pending commit
    wframe(8'h03, 8'h11);
    wframe(8'h10, 8'h00);
    tick();
    chk("pre_rst_pending", commit_pending, 1);
    send_byte(8'hA5);
    send_byte(8'h02);
    rst = 1'b1;
    repeat (2) tick();
    rst = 1'b0;
    sh = DEF;
    chk("rst_err", err_cnt, 0);
    chk("rst_pending", commit_pending, 0);
    chk("rst_active", act, DEF);
    send_byte(8'h40);
    send_byte(8'h40);
    chk("rst_abort_no_err", err_cnt, 0);
    pulse_sync(1'b0, sh);
    wframe(8'h04, 8'h77);
    wframe(8'h11, 8'h00);
    repeat (4) tick();
    chk("post_rst_phase", state_phase, 8'h77);

    repeat (5) tick();
    chk("scoreboard_drained", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
